tuple_meta_bridge: RTL



---
 rtl/tuple_meta_bridge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tuple_meta_bridge.sv
// Tuple side-channel bridge around the packet processor: snoops input SOP tuser into tuple_in,
// queues tuple_out results and re-attaches them as m_axis_tuser. Optional: TUPLE_BRIDGE_TUSER_HOLD_EN.
module tuple_meta_bridge #(
    parameter int TDATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128,
    parameter int TUPLE_WIDTH = 128,
    parameter int FIFO_DEPTH  = 4,
    parameter int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk_line,
    input  logic                     clk_line_rst,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
    output logic                     tin_valid,
    output logic [TUPLE_WIDTH-1:0]   tin_data,
    input  logic                     tout_valid,
    input  logic [TUPLE_WIDTH-1:0]   tout_data,
    input  logic [TDATA_WIDTH-1:0]   p_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] p_axis_tkeep,
    input  logic                     p_axis_tvalid,
    input  logic                     p_axis_tlast,
    output logic                     p_axis_tready,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic [AW:0]              fifo_level,
    output logic                     ovf_flag,
    output logic [15:0]              ovf_cnt
);

    typedef enum logic {IN_SOP = 1'b0, IN_BODY = 1'b1} in_state_t;
    typedef enum logic {OUT_SOP = 1'b0, OUT_BODY = 1'b1} out_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [TUSER_WIDTH-1:0] ext_tuple(input logic [TUPLE_WIDTH-1:0] t);
        logic [TUSER_WIDTH-1:0] r;
        r = '0;
        r[TUPLE_WIDTH-1:0] = t;
        return r;
    endfunction

    in_state_t  in_state, in_state_nxt;
    out_state_t out_state, out_state_nxt;

    logic                   s_acc;
    logic                   sop_acc;
    logic [TUPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            level;
    logic                   full, empty, push, pop, drop;
    logic                   m_hs;

    // Ingress: SOP snoop into a one-cycle tuple_in pulse
    assign s_acc   = s_axis_tvalid & s_axis_tready;
    assign sop_acc = (in_state == IN_SOP) & s_acc;

    always_comb begin
        in_state_nxt = in_state;
        case (in_state)
            IN_SOP:  if (s_acc && !s_axis_tlast) in_state_nxt = IN_BODY;
            IN_BODY: if (s_acc && s_axis_tlast)  in_state_nxt = IN_SOP;
            default: in_state_nxt = IN_SOP;
        endcase
    end

    always_ff @(posedge clk_line) begin
        if (clk_line_rst) begin
            in_state  <= IN_SOP;
            tin_valid <= 1'b0;
            tin_data  <= '0;
        end else begin
            in_state  <= in_state_nxt;
            tin_valid <= sop_acc;
            if (sop_acc) tin_data <= s_axis_tuser[TUPLE_WIDTH-1:0];
        end
    end

    // Tuple FIFO: a pop frees the slot for a same-cycle push even when full
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign m_hs  = m_axis_tvalid & m_axis_tready;
    assign pop   = (out_state == OUT_SOP) & m_hs;
    assign push  = tout_valid & (~full | pop);
    assign drop  = tout_valid & full & ~pop;

    always_ff @(posedge clk_line) begin
        if (push) mem[wr_ptr] <= tout_data;
    end

    always_ff @(posedge clk_line) begin
        if (clk_line_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                ovf_flag <= 1'b1;
                ovf_cnt  <= sat_inc16(ovf_cnt);
            end
        end
    end

    assign fifo_level = level;

`ifdef TUPLE_BRIDGE_TUSER_HOLD_EN
    logic [TUPLE_WIDTH-1:0] tuple_hold;

    always_ff @(posedge clk_line) begin
        if (pop) tuple_hold <= mem[rd_ptr];
    end
`endif

    // Egress: gate the SOP beat on tuple availability, pass the body through
    always_comb begin
        out_state_nxt = out_state;
        m_axis_tvalid = p_axis_tvalid;
        p_axis_tready = m_axis_tready;
        m_axis_tuser  = '0;
        case (out_state)
            OUT_SOP: begin
                m_axis_tvalid = p_axis_tvalid & ~empty;
                p_axis_tready = m_axis_tready & ~empty;
                m_axis_tuser  = ext_tuple(mem[rd_ptr]);
                if (m_axis_tvalid && m_axis_tready && !p_axis_tlast) out_state_nxt = OUT_BODY;
            end
            OUT_BODY: begin
`ifdef TUPLE_BRIDGE_TUSER_HOLD_EN
                m_axis_tuser = ext_tuple(tuple_hold);
`endif
                if (m_axis_tvalid && m_axis_tready && p_axis_tlast) out_state_nxt = OUT_SOP;
            end
            default: out_state_nxt = OUT_SOP;
        endcase
    end

    always_ff @(posedge clk_line) begin
        if (clk_line_rst) out_state <= OUT_SOP;
        else              out_state <= out_state_nxt;
    end

    assign m_axis_tdata = p_axis_tdata;
    assign m_axis_tkeep = p_axis_tkeep;
    assign m_axis_tlast = p_axis_tlast;

endmodule
